// File: rtl/scm16_seq_pkg.sv
// Shared encodings for the SCM16 fetch sequencer: operation kinds, FSM states
// and the default address width.
package scm16_seq_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef logic [1:0] op_kind_t;
  typedef logic [1:0] seq_state_t;

  localparam op_kind_t OP_SEQ    = 2'd0;
  localparam op_kind_t OP_BRANCH = 2'd1;
  localparam op_kind_t OP_CALL   = 2'd2;
  localparam op_kind_t OP_RET    = 2'd3;

  localparam seq_state_t ST_RUN   = 2'd0;
  localparam seq_state_t ST_FLUSH = 2'd1;
  localparam seq_state_t ST_FAULT = 2'd2;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address LIFO. Only the occupancy count is reset; entry
// contents are don't-care once the count drops below them.
module ret_stack #(
  parameter  int ADDR_W = 16,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the low bits of count index the next free slot
  // and wrapping (count-1) lands on the top entry even when full.
  assign wr_idx = count_q[IDX_W-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign dout   = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + 1'b1;
    end else if (do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// SCM16 program counter and fetch sequencer: acts on the condition result for
// step/branch/call/return and owns the return-address stack.
module pc_sequencer
  import scm16_seq_pkg::*;
#(
  parameter  int                ADDR_W      = ADDR_W_DEF,
  parameter  int                STACK_DEPTH = 8,
  parameter  logic [ADDR_W-1:0] RESET_PC    = '0,
  localparam int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_kind,
  input  logic              cond_taken,
  input  logic [ADDR_W-1:0] target,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              redirect,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic [SP_W-1:0]   sp_count
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              accept;
  logic [ADDR_W-1:0] pc_inc;
  logic              stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  assign pc_valid  = (state_q == ST_RUN);
  assign op_ready  = pc_valid & fetch_ready;
  assign accept    = op_valid & op_ready;
  assign pc_inc    = pc_q + 1'b1;
  assign pc        = pc_q;
  assign redirect  = redirect_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (sp_count)
  );

  // redirect defaults low: it is only raised for the single FLUSH cycle that
  // follows a taken non-sequential load.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    case (state_q)
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          case (op_kind)
            OP_SEQ: pc_d = pc_inc;
            OP_BRANCH: begin
              if (cond_taken) begin
                pc_d       = target;
                redirect_d = 1'b1;
                state_d    = ST_FLUSH;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_CALL: begin
              if (!cond_taken) begin
                pc_d = pc_inc;
              end else if (stk_full) begin
                ovf_d   = 1'b1;
                state_d = ST_FAULT;
              end else begin
                stk_push   = 1'b1;
                pc_d       = target;
                redirect_d = 1'b1;
                state_d    = ST_FLUSH;
              end
            end
            OP_RET: begin
              if (!cond_taken) begin
                pc_d = pc_inc;
              end else if (stk_empty) begin
                unf_d   = 1'b1;
                state_d = ST_FAULT;
              end else begin
                stk_pop    = 1'b1;
                pc_d       = stk_top;
                redirect_d = 1'b1;
                state_d    = ST_FLUSH;
              end
            end
          endcase
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FLUSH;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each step drives one cycle of
// inputs and queues the hand-computed outputs expected during that cycle.
module tb_pc_sequencer;

  localparam int K_SEQ = 0;
  localparam int K_BR  = 1;
  localparam int K_CALL = 2;
  localparam int K_RET = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_kind = 2'd0;
  logic        cond_taken = 1'b0;
  logic [15:0] target = 16'h0;
  logic        fetch_ready = 1'b0;
  logic        op_ready, pc_valid, redirect, stack_ovf, stack_unf;
  logic [15:0] pc;
  logic [3:0]  sp_count;

  typedef struct {
    int          id;
    int          cyc;
    logic [15:0] pc;
    logic        pv;
    logic        rd;
    logic        rdy;
    logic [3:0]  sp;
    logic [1:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   vec_id = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_kind     (op_kind),
    .cond_taken  (cond_taken),
    .target      (target),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf),
    .sp_count    (sp_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: outputs are checked mid-cycle against whatever was queued for it.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      tests++;
      if (e.cyc != cyc || pc !== e.pc || pc_valid !== e.pv || redirect !== e.rd ||
          op_ready !== e.rdy || sp_count !== e.sp || {stack_ovf, stack_unf} !== e.fl) begin
        fails++;
        $display("FAIL vec%0d cyc%0d: got pc=%h pv=%b rd=%b rdy=%b sp=%0d ovf/unf=%b%b, required pc=%h pv=%b rd=%b rdy=%b sp=%0d ovf/unf=%b",
                 e.id, cyc, pc, pc_valid, redirect, op_ready, sp_count, stack_ovf, stack_unf,
                 e.pc, e.pv, e.rd, e.rdy, e.sp, e.fl);
      end else begin
        $display("[TB] vec%0d cyc%0d pc=%h pv=%b rd=%b rdy=%b sp=%0d ovf/unf=%b%b",
                 e.id, cyc, pc, pc_valid, redirect, op_ready, sp_count, stack_ovf, stack_unf);
      end
    end
  end

  task automatic step(input int r, input int v, input int k, input int c, input int t,
                      input int fr, input int e_pc, input int e_pv, input int e_rd,
                      input int e_rdy, input int e_sp, input int e_fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r[0];
    op_valid    = v[0];
    op_kind     = k[1:0];
    cond_taken  = c[0];
    target      = t[15:0];
    fetch_ready = fr[0];
    e.id  = vec_id;
    e.cyc = cyc;
    e.pc  = e_pc[15:0];
    e.pv  = e_pv[0];
    e.rd  = e_rd[0];
    e.rdy = e_rdy[0];
    e.sp  = e_sp[3:0];
    e.fl  = e_fl[1:0];
    sb_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    // Reset, release, then straight-line SEQ stepping.
    step(0,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'h0,1,0,1,0,0);
    step(1,1,K_SEQ,0,0,1,      'h1,1,0,1,0,0);
    step(1,1,K_SEQ,0,0,1,      'h2,1,0,1,0,0);
    step(1,1,K_BR,1,'h5,1,     'h3,1,0,1,0,0);
    step(1,1,K_BR,1,'h40,1,    'h5,0,1,0,0,0);
    // Taken branch 0x5 -> 0x40.
    step(1,1,K_BR,1,'h40,1,    'h5,1,0,1,0,0);
    step(1,1,K_BR,1,'h5,1,     'h40,0,1,0,0,0);
    step(1,1,K_BR,1,'h5,1,     'h40,1,0,1,0,0);
    // Not-taken branch from 0x5.
    step(1,1,K_BR,0,'h40,1,    'h5,0,1,0,0,0);
    step(1,1,K_BR,0,'h40,1,    'h5,1,0,1,0,0);
    // Branch to pc+1 is still a redirect.
    step(1,1,K_BR,1,'h7,1,     'h6,1,0,1,0,0);
    step(1,1,K_BR,1,'h10,1,    'h7,0,1,0,0,0);
    step(1,1,K_BR,1,'h10,1,    'h7,1,0,1,0,0);
    // CALL 0x10 -> 0x100, two SEQ, RET to 0x11.
    step(1,1,K_CALL,1,'h100,1, 'h10,0,1,0,0,0);
    step(1,1,K_CALL,1,'h100,1, 'h10,1,0,1,0,0);
    step(1,1,K_SEQ,0,0,1,      'h100,0,1,0,1,0);
    step(1,1,K_SEQ,0,0,1,      'h100,1,0,1,1,0);
    step(1,1,K_SEQ,0,0,1,      'h101,1,0,1,1,0);
    step(1,1,K_RET,1,0,1,      'h102,1,0,1,1,0);
    step(1,1,K_RET,0,0,1,      'h11,0,1,0,0,0);
    // Not-taken RET on empty stack just steps; not-taken CALL too.
    step(1,1,K_RET,0,0,1,      'h11,1,0,1,0,0);
    step(1,1,K_CALL,0,'h200,1, 'h12,1,0,1,0,0);
    // fetch_ready low for three cycles stalls everything.
    step(1,1,K_SEQ,0,0,0,      'h13,1,0,0,0,0);
    step(1,1,K_SEQ,0,0,0,      'h13,1,0,0,0,0);
    step(1,1,K_SEQ,0,0,0,      'h13,1,0,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'h13,1,0,1,0,0);
    // Address wrap at 0xFFFF for SEQ and for the pushed return address.
    step(1,1,K_BR,1,'hFFFF,1,  'h14,1,0,1,0,0);
    step(1,1,K_SEQ,0,0,1,      'hFFFF,0,1,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'hFFFF,1,0,1,0,0);
    step(1,1,K_BR,1,'hFFFF,1,  'h0,1,0,1,0,0);
    step(1,1,K_CALL,1,'h300,1, 'hFFFF,0,1,0,0,0);
    step(1,1,K_CALL,1,'h300,1, 'hFFFF,1,0,1,0,0);
    step(1,1,K_RET,1,0,1,      'h300,0,1,0,1,0);
    step(1,1,K_RET,1,0,1,      'h300,1,0,1,1,0);
    // Taken RET on empty stack: underflow fault, pc held.
    step(1,1,K_RET,1,0,1,      'h0,0,1,0,0,0);
    step(1,1,K_RET,1,0,1,      'h0,1,0,1,0,0);
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,1);
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,1);
    step(0,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    // Fill the stack with eight taken CALLs.
    for (int i = 0; i < 8; i++) begin
      step(1,1,K_CALL,1,'h1000+i,1, (i == 0) ? 'h0 : 'h1000+i-1, 1,0,1,i,0);
      step(1,1,K_CALL,1,'h1000+i,1, 'h1000+i, 0,1,0,i+1,0);
    end
    // Ninth CALL overflows; fault is terminal until reset.
    step(1,1,K_CALL,1,'h2000,1,'h1007,1,0,1,8,0);
    step(1,1,K_SEQ,0,0,1,      'h1007,0,0,0,8,2);
    step(1,1,K_SEQ,0,0,1,      'h1007,0,0,0,8,2);
    // Reset mid-FAULT: pc returns to RESET_PC before the next edge.
    step(0,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_BR,1,'hABC,1,   'h0,1,0,1,0,0);
    // Reset mid-FLUSH (pc was 0xABC) clears pc and redirect at once.
    step(0,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    // Nested CALLs then RETs: LIFO ordering.
    step(1,1,K_SEQ,0,0,1,      'h0,0,0,0,0,0);
    step(1,1,K_CALL,1,'h50,1,  'h0,1,0,1,0,0);
    step(1,1,K_CALL,1,'h60,1,  'h50,0,1,0,1,0);
    step(1,1,K_CALL,1,'h60,1,  'h50,1,0,1,1,0);
    step(1,1,K_RET,1,0,1,      'h60,0,1,0,2,0);
    step(1,1,K_RET,1,0,1,      'h60,1,0,1,2,0);
    step(1,1,K_RET,1,0,1,      'h51,0,1,0,1,0);
    step(1,1,K_RET,1,0,1,      'h51,1,0,1,1,0);
    // op_valid low: nothing accepted, pc holds.
    step(1,0,K_SEQ,0,0,1,      'h1,0,1,0,0,0);
    step(1,0,K_SEQ,0,0,1,      'h1,1,0,1,0,0);
    step(1,0,K_SEQ,0,0,1,      'h1,1,0,1,0,0);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
